// File: rtl/pipe_mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package pipe_mdu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int CNTW_DEF = 6;

    typedef enum logic [2:0] {
        MDOP_NONE  = 3'd0,
        MDOP_MULT  = 3'd1,
        MDOP_MULTU = 3'd2,
        MDOP_DIV   = 3'd3,
        MDOP_DIVU  = 3'd4,
        MDOP_MTHI  = 3'd5,
        MDOP_MTLO  = 3'd6,
        MDOP_RSVD  = 3'd7
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*XLEN accumulator.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    input  logic              div_mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [2*XLEN:0] sh;
    logic [XLEN:0]   diff;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        sh       = {acc, 1'b0};
        diff     = sh[2*XLEN:XLEN] - {1'b0, opnd};
        acc_next = {sum, acc[XLEN-1:1]};
        // Divide: a borrow out of the trial subtraction restores the shifted remainder
        if (div_mode) begin
            acc_next = diff[XLEN] ? sh[2*XLEN-1:0] : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/pipe_mdu_ctl.sv
// Multi-cycle MUL/DIV sequencer owning HI/LO; stalls IF/ID/EXE while iterating.
// Optional MDU_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module pipe_mdu_ctl
    import pipe_mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [2:0]      emdop,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic            ecancel,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdop_e             op;
    state_e            state;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] acc, acc_next, acc_fin;
    logic [XLEN-1:0]   opnd, mag_a, mag_b;
    logic              div_mode, neg_q, neg_r;
    logic              is_md, is_div, is_sgn, start, last;

    function automatic logic [XLEN-1:0] sfix(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] sfix2(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    assign op     = mdop_e'(emdop);
    assign is_md  = op inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};
    assign is_div = (op == MDOP_DIV) || (op == MDOP_DIVU);
    assign is_sgn = (op == MDOP_MULT) || (op == MDOP_DIV);
    assign mag_a  = (is_sgn && ea[XLEN-1]) ? -ea : ea;
    assign mag_b  = (is_sgn && eb[XLEN-1]) ? -eb : eb;
    assign start  = (state == ST_IDLE) && is_md && !ecancel;
    assign stall  = start || ((state == ST_RUN) && !ecancel);

`ifdef MDU_EARLY_TERM_EN
    logic [XLEN-1:0] mreg;

    always_ff @(posedge clock) begin
        if (start) begin
            mreg <= mag_b;
        end else if (state == ST_RUN) begin
            mreg <= mreg >> 1;
        end
    end

    // Skipped iterations would only shift, so the final cycle applies them all at once
    assign last    = (cnt == CNTW'(1)) || (!div_mode && ((mreg >> 1) == '0));
    assign acc_fin = acc_next >> (cnt - CNTW'(1));
`else
    assign last    = (cnt == CNTW'(1));
    assign acc_fin = acc_next;
`endif

    mdu_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .div_mode (div_mode),
        .acc_next (acc_next)
    );

    always_ff @(posedge clock) begin
        if (start) begin
            div_mode <= is_div;
            neg_q    <= is_sgn && (ea[XLEN-1] ^ eb[XLEN-1]);
            neg_r    <= is_sgn && is_div && ea[XLEN-1];
            acc      <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            opnd     <= is_div ? mag_b : mag_a;
        end else if (state == ST_RUN) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= CNTW'(XLEN);
                        busy  <= 1'b1;
                    end else if (!ecancel && op == MDOP_MTHI) begin
                        hi <= ea;
                    end else if (!ecancel && op == MDOP_MTLO) begin
                        lo <= ea;
                    end
                end
                ST_RUN: begin
                    if (ecancel) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (div_mode) begin
                            lo <= sfix(neg_q, acc_fin[XLEN-1:0]);
                            hi <= sfix(neg_r, acc_fin[2*XLEN-1:XLEN]);
                        end else begin
                            {hi, lo} <= sfix2(neg_q, acc_fin);
                        end
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mdu_ctl.sv
// Directed bench for pipe_mdu_ctl: vector table of mul/div ops plus hand sequences.
module tb_pipe_mdu_ctl;
    import pipe_mdu_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  emdop = 3'd0;
    logic [31:0] ea = '0;
    logic [31:0] eb = '0;
    logic        ecancel = 1'b0;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          st;
        int          st_et;
    } vec_t;

    vec_t vt[12];

    pipe_mdu_ctl #(.XLEN(32), .CNTW(6)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .emdop   (emdop),
        .ea      (ea),
        .eb      (eb),
        .ecancel (ecancel),
        .stall   (stall),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue an op from an IDLE cycle and count stall/busy cycles until the first DONE cycle
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int nb);
        emdop = op;
        ea    = a;
        eb    = b;
        #1;
        n  = 0;
        nb = 0;
        while (stall && n < 100) begin
            n++;
            if (busy) nb++;
            @(negedge clock);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi0, lo0;
        int n, nb;

        vt[0]  = '{MDOP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33, 3};
        vt[1]  = '{MDOP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 4};
        vt[2]  = '{MDOP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
        vt[3]  = '{MDOP_DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 33, 33};
        vt[4]  = '{MDOP_MULTU, 32'd5,        32'd1,        32'h00000000, 32'h00000005, 33, 2};
        vt[5]  = '{MDOP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 2};
        vt[6]  = '{MDOP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33};
        vt[7]  = '{MDOP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33, 33};
        vt[8]  = '{MDOP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 2};
        vt[9]  = '{MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
        vt[10] = '{MDOP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'h00000001, 33, 33};
        vt[11] = '{MDOP_MULT,  32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 33, 30};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clock);

        // MTHI / MTLO and a cancelled MTLO
        emdop = MDOP_MTHI; ea = 32'hCAFE0001;
        #1 chk("mthi_stall", stall, 0);
        @(negedge clock);
        chk("mthi_hi", hi, 32'hCAFE0001);
        emdop = MDOP_MTLO; ea = 32'hCAFE0002;
        #1 chk("mtlo_stall", stall, 0);
        @(negedge clock);
        chk("mtlo_lo", lo, 32'hCAFE0002);
        emdop = MDOP_MTLO; ea = 32'h00001234; ecancel = 1'b1;
        @(negedge clock);
        chk("mtlo_cancel_lo", lo, 32'hCAFE0002);
        chk("mtlo_cancel_hi", hi, 32'hCAFE0001);
        emdop = MDOP_NONE; ecancel = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            int es;
`ifdef MDU_EARLY_TERM_EN
            es = vt[i].st_et;
`else
            es = vt[i].st;
`endif
            run_md(vt[i].op, vt[i].a, vt[i].b, n, nb);
            chk($sformatf("v%0d_stall_cycles", i), n, es);
            chk($sformatf("v%0d_busy_cycles", i), nb, es - 1);
            chk($sformatf("v%0d_hi", i), hi, vt[i].ehi);
            chk($sformatf("v%0d_lo", i), lo, vt[i].elo);
            chk($sformatf("v%0d_done_busy", i), busy, 0);
            emdop = MDOP_NONE;
            @(negedge clock);
        end

        // Cancel in RUN cycle 10: abort, stall drops at once, HI/LO untouched
        hi0 = hi; lo0 = lo;
        emdop = MDOP_MULT; ea = 32'd3; eb = 32'd5;
        #1 chk("cancel_issue_stall", stall, 1);
        repeat (10) @(negedge clock);
        chk("cancel_run_busy", busy, 1);
        ecancel = 1'b1;
        #1 chk("cancel_stall_drop", stall, 0);
        @(negedge clock);
        chk("cancel_idle_busy", busy, 0);
        chk("cancel_idle_stall", stall, 0);
        emdop = MDOP_NONE; ecancel = 1'b0;
        repeat (40) @(negedge clock);
        chk("cancel_hi", hi, hi0);
        chk("cancel_lo", lo, lo0);

        // Back-to-back DIVU then MTHI issued right after DONE
        run_md(MDOP_DIVU, 32'd10, 32'd3, n, nb);
        chk("b2b_div_stall", n, 33);
        chk("b2b_div_lo", lo, 3);
        chk("b2b_div_hi", hi, 1);
        emdop = MDOP_MTHI; ea = 32'h0000ABCD;
        @(negedge clock);
        chk("b2b_mthi_stall", stall, 0);
        chk("b2b_mthi_hi_before", hi, 1);
        @(negedge clock);
        chk("b2b_mthi_hi", hi, 32'h0000ABCD);
        chk("b2b_mthi_lo", lo, 3);
        chk("b2b_mthi_busy", busy, 0);
        emdop = MDOP_NONE;
        @(negedge clock);

        // Asynchronous reset in the middle of RUN
        emdop = MDOP_MULTU; ea = 32'd7; eb = 32'd9;
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        emdop = MDOP_NONE;
        #1 chk("arst_stall", stall, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_md(MDOP_MULTU, 32'd7, 32'd9, n, nb);
        chk("post_rst_lo", lo, 63);
        chk("post_rst_hi", hi, 0);
        emdop = MDOP_NONE;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
